// File: rtl/pc_fetch_pkg.sv
// Shared fetch-side definitions: bubble encoding, hold-flag decode,
// and the prefetch entry layout.
package zarv_defs;

    localparam logic [31:0] INST_BUBBLE = 32'h0000_0001;
    localparam logic [2:0]  HOLD_NONE   = 3'd0;
    localparam logic [2:0]  HOLD_STALL  = 3'd1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic is_flush(input logic [2:0] h);
        return h > HOLD_STALL;
    endfunction

endpackage

// File: rtl/pc_fetch_fifo.sv
// Prefetch buffer: DEPTH entries of {addr, inst}, head read combinationally
// from storage, clear takes priority over push/pop.
module fetch_fifo
    import zarv_defs::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            push,
    input  fetch_entry_t    push_data,
    input  logic            pop,
    output fetch_entry_t    head,
    output logic [CW-1:0]   count
);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear)
            mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/pc_fetch.sv
// Program counter and instruction fetch front end feeding IF/ID:
// request/grant bus with in-order responses, prefetch FIFO, flush redirect.
module pc_fetch
    import zarv_defs::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  hold_flag_i,
    input  logic [31:0] jump_addr_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_addr_o,
    output logic [31:0] inst_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(DEPTH);

    logic [31:0]   req_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] out_next;
    logic [CW-1:0] count;
    logic [CW:0]   occ;
    logic [31:0]   target;
    fetch_entry_t  head;
    fetch_entry_t  push_data;
    logic          flush;
    logic          hs;
    logic          drop;
    logic          take;
    logic          push;
    logic          pop;

    assign flush  = is_flush(hold_flag_i);
    assign target = jump_addr_i & ~32'h3;
    assign occ    = {1'b0, count} + {1'b0, outstanding};

    assign ibus_req_o = rst_n && (discard == '0) && (occ < DEPTH_L)
                     && (hold_flag_i <= HOLD_STALL);
    assign ibus_addr_o = req_pc;

    assign hs   = ibus_req_o && ibus_gnt_i;
    assign drop = ibus_rvalid_i && (discard != '0);
    assign take = ibus_rvalid_i && (discard == '0);
    assign push = take && !flush;
    assign pop  = inst_valid_o && (hold_flag_i == HOLD_NONE);

    assign out_next = outstanding + CW'(hs) - CW'(ibus_rvalid_i);

    assign push_data.addr = resp_pc;
    assign push_data.inst = ibus_rdata_i;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_pc      <= RESET_ADDR;
            resp_pc     <= RESET_ADDR;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= out_next;
            if (flush) begin
                // every fetch still in flight after this edge is stale
                req_pc  <= target;
                resp_pc <= target;
                discard <= out_next;
            end else begin
                if (hs)
                    req_pc <= req_pc + 32'd4;
                if (take)
                    resp_pc <= resp_pc + 32'd4;
                if (drop)
                    discard <= discard - CW'(1);
            end
        end
    end

    assign inst_valid_o = (count != '0);
    assign inst_o       = inst_valid_o ? head.inst : INST_BUBBLE;
    assign inst_addr_o  = inst_valid_o ? head.addr : resp_pc;

    a_cap: assert property (@(posedge clk) disable iff (!rst_n)
        occ <= DEPTH_L);

    a_no_orphan: assert property (@(posedge clk) disable iff (!rst_n)
        ibus_rvalid_i |-> (outstanding != '0));

endmodule

// File: tb/tb_pc_fetch.sv
// Randomized bus/hold stimulus against a queue-based model of the
// fetch front end: in-flight fetches, stale marking, prefetch contents.
module tb_pc_fetch;

    localparam logic [31:0] RA     = 32'h0000_0000;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] BUBBLE = 32'h0000_0001;
    localparam logic [31:0] SALT   = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  hold_flag_i;
    logic [31:0] jump_addr_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_addr_o;
    logic [31:0] inst_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] addr;
        int          gcyc;
        bit          stale;
    } flight_t;

    flight_t     q[$];
    logic [31:0] fifo[$];
    logic [31:0] m_req_pc;

    always #5 clk = ~clk;

    pc_fetch #(.RESET_ADDR(RA), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .hold_flag_i   (hold_flag_i),
        .jump_addr_i   (jump_addr_i),
        .ibus_req_o    (ibus_req_o),
        .ibus_addr_o   (ibus_addr_o),
        .ibus_gnt_i    (ibus_gnt_i),
        .ibus_rvalid_i (ibus_rvalid_i),
        .ibus_rdata_i  (ibus_rdata_i),
        .inst_valid_o  (inst_valid_o),
        .inst_addr_o   (inst_addr_o),
        .inst_o        (inst_o)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit any_stale();
        foreach (q[i]) if (q[i].stale) return 1'b1;
        return 1'b0;
    endfunction

    // next address the front end expects a response for
    function automatic logic [31:0] next_resp();
        foreach (q[i]) if (!q[i].stale) return q[i].addr;
        return m_req_pc;
    endfunction

    task automatic step(input logic [2:0] h, input logic [31:0] j,
                        input bit g, input bit rv);
        flight_t r;
        bit      exp_req;
        bit      do_pop;
        bit      hs;
        bit      got_rv;
        @(negedge clk);
        hold_flag_i   = h;
        jump_addr_i   = j;
        ibus_gnt_i    = g;
        ibus_rvalid_i = 1'b0;
        ibus_rdata_i  = '0;
        if (rv && q.size() > 0 && q[0].gcyc < cyc) begin
            ibus_rvalid_i = 1'b1;
            ibus_rdata_i  = q[0].addr ^ SALT;
        end
        #1;
        exp_req = (h <= 3'd1) && (fifo.size() + q.size() < DEPTH)
                  && !any_stale();
        chk("req", 32'(ibus_req_o), 32'(exp_req));
        if (exp_req)
            chk("ibus_addr", ibus_addr_o, m_req_pc);
        if (fifo.size() > 0) begin
            chk("valid", 32'(inst_valid_o), 32'd1);
            chk("inst_addr", inst_addr_o, fifo[0]);
            chk("inst", inst_o, fifo[0] ^ SALT);
        end else begin
            chk("valid", 32'(inst_valid_o), 32'd0);
            chk("idle_addr", inst_addr_o, next_resp());
            chk("bubble", inst_o, BUBBLE);
        end
        do_pop = (fifo.size() > 0) && (h == 3'd0);
        hs     = ibus_req_o && g;
        got_rv = ibus_rvalid_i;
        if (do_pop)
            void'(fifo.pop_front());
        if (got_rv) begin
            r = q.pop_front();
            if (!r.stale && h <= 3'd1)
                fifo.push_back(r.addr);
        end
        if (hs) begin
            q.push_back('{m_req_pc, cyc, 1'b0});
            m_req_pc = m_req_pc + 32'd4;
        end
        if (h > 3'd1) begin
            fifo.delete();
            foreach (q[i]) q[i].stale = 1'b1;
            m_req_pc = {j[31:2], 2'b00};
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        hold_flag_i   = 3'd0;
        jump_addr_i   = '0;
        ibus_gnt_i    = 1'b0;
        ibus_rvalid_i = 1'b0;
        ibus_rdata_i  = '0;
        @(negedge clk);
        #1;
        chk("rst_req", 32'(ibus_req_o), 32'd0);
        chk("rst_valid", 32'(inst_valid_o), 32'd0);
        chk("rst_inst", inst_o, BUBBLE);
        chk("rst_addr", inst_addr_o, RA);
        rst_n = 1'b1;
        q.delete();
        fifo.delete();
        m_req_pc = RA;
        cyc++;
    endtask

    initial begin
        logic [31:0] a0;
        int          r;
        rst_n = 1'b0;
        m_req_pc = RA;
        // streaming with grants every cycle and 1-cycle responses
        do_reset();
        repeat (12) step(3'd0, '0, 1'b1, 1'b1);
        // grant withheld with a request pending
        repeat (3) step(3'd0, '0, 1'b0, 1'b1);
        a0 = ibus_addr_o;
        repeat (3) begin
            step(3'd0, '0, 1'b0, 1'b1);
            chk("addr_stable", ibus_addr_o, a0);
        end
        repeat (4) step(3'd0, '0, 1'b1, 1'b1);
        // stall mid-stream
        repeat (4) step(3'd1, '0, 1'b1, 1'b1);
        repeat (6) step(3'd0, '0, 1'b1, 1'b1);
        // two fetches outstanding, then redirect
        step(3'd0, '0, 1'b1, 1'b0);
        step(3'd0, '0, 1'b1, 1'b0);
        step(3'd2, 32'h0000_1002, 1'b1, 1'b0);
        repeat (2) step(3'd0, '0, 1'b0, 1'b1);
        chk("redir_addr", ibus_addr_o, 32'h0000_1000);
        repeat (6) step(3'd0, '0, 1'b1, 1'b1);
        // flush with grant and response presented together
        step(3'd0, '0, 1'b1, 1'b0);
        step(3'd5, 32'h0000_2000, 1'b1, 1'b1);
        step(3'd3, 32'h0000_3004, 1'b1, 1'b1);
        repeat (8) step(3'd0, '0, 1'b1, 1'b1);
        // wrap at the top of the address space, then reset mid-stream
        step(3'd2, 32'hFFFF_FFFC, 1'b1, 1'b1);
        repeat (8) step(3'd0, '0, 1'b1, 1'b1);
        do_reset();
        repeat (4) step(3'd0, '0, 1'b1, 1'b1);
        // random traffic
        repeat (600) begin
            r = $urandom_range(0, 99);
            step((r < 70) ? 3'd0 : (r < 88) ? 3'd1
                     : 3'($urandom_range(2, 7)),
                 $urandom,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) != 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
